// File: rtl/video_pkg.sv
// Shared definitions for the moving-square video block scheduler.
// Holds the scheduler FSM state encoding, the coordinate width and the
// helpers that derive the legal position range of the square on one axis.
package video_pkg;

  localparam int COORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VB = 2'd1,
    ST_CALC    = 2'd2,
    ST_COMMIT  = 2'd3
  } sched_state_t;

  // Smallest legal left/top edge: just inside the border.
  function automatic logic [COORD_W-1:0] axis_min(input int side_w);
    return COORD_W'(side_w);
  endfunction

  // Largest legal left/top edge: square touches the far border.
  function automatic logic [COORD_W-1:0] axis_max(input int disp, input int side_w,
                                                  input int block_w);
    return COORD_W'(disp - side_w - block_w);
  endfunction

  function automatic logic [COORD_W-1:0] xmin_f(input int side_w);
    return axis_min(side_w);
  endfunction

  function automatic logic [COORD_W-1:0] xmax_f(input int h_disp, input int side_w,
                                                input int block_w);
    return axis_max(h_disp, side_w, block_w);
  endfunction

  function automatic logic [COORD_W-1:0] ymin_f(input int side_w);
    return axis_min(side_w);
  endfunction

  function automatic logic [COORD_W-1:0] ymax_f(input int v_disp, input int side_w,
                                                input int block_w);
    return axis_max(v_disp, side_w, block_w);
  endfunction

endpackage

// File: rtl/video_block_scheduler_axis_bounce.sv
// axis_bounce: combinational next position and direction of the square on
// one axis. Moves pos by step toward the current direction and clamps to
// [pos_min, pos_max], flipping direction when a bound is reached.
// Ports:
//   pos, step, dir        current position, step size, direction (1 = increasing)
//   pos_min, pos_max      legal range on this axis
//   pos_nxt, dir_nxt      position and direction after one update
module axis_bounce
  import video_pkg::*;
(
  input  logic [COORD_W-1:0] pos,
  input  logic [7:0]         step,
  input  logic               dir,
  input  logic [COORD_W-1:0] pos_min,
  input  logic [COORD_W-1:0] pos_max,
  output logic [COORD_W-1:0] pos_nxt,
  output logic               dir_nxt
);

  // One extra bit so pos+step and min+step can never wrap.
  logic [COORD_W:0] fwd_sum;
  logic [COORD_W:0] back_lim;

  assign fwd_sum  = {1'b0, pos} + {{(COORD_W-7){1'b0}}, step};
  assign back_lim = {1'b0, pos_min} + {{(COORD_W-7){1'b0}}, step};

  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    if (dir) begin
      if (fwd_sum >= {1'b0, pos_max}) begin
        pos_nxt = pos_max;
        dir_nxt = 1'b0;
      end else begin
        pos_nxt = fwd_sum[COORD_W-1:0];
      end
    end else begin
      // pos <= min+step also covers steps larger than the whole range.
      if ({1'b0, pos} <= back_lim) begin
        pos_nxt = pos_min;
        dir_nxt = 1'b1;
      end else begin
        pos_nxt = pos - {{(COORD_W-8){1'b0}}, step};
      end
    end
  end

endmodule

// File: rtl/video_block_scheduler.sv
// video_block_scheduler: moves a square around the active video area,
// bouncing off the border. Position updates are computed and committed
// inside vertical blank so the displayed square never tears.
// Ports:
//   pixel_clk, rst        clock and asynchronous active-high reset
//   vblank                vertical blank from the timing generator
//   enable                motion enable
//   cfg_valid/cfg_ready   handshake for a new cfg_step / cfg_div
//   cfg_step              pixels moved per update
//   cfg_div               frames per update (0 behaves as 1)
//   block_x, block_y      top-left corner of the square
//   dir_x, dir_y          1 = moving right / down
//   pos_upd               one-cycle pulse when a new position is committed
module video_block_scheduler
  import video_pkg::*;
#(
  parameter int H_DISP    = 1920,
  parameter int V_DISP    = 1080,
  parameter int SIDE_W    = 40,
  parameter int BLOCK_W   = 80,
  parameter int STEP_INIT = 1,
  parameter int DIV_INIT  = 1
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               vblank,
  input  logic               enable,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [7:0]         cfg_step,
  input  logic [7:0]         cfg_div,
  output logic [COORD_W-1:0] block_x,
  output logic [COORD_W-1:0] block_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic               pos_upd
);

  localparam logic [COORD_W-1:0] XMIN = xmin_f(SIDE_W);
  localparam logic [COORD_W-1:0] XMAX = xmax_f(H_DISP, SIDE_W, BLOCK_W);
  localparam logic [COORD_W-1:0] YMIN = ymin_f(SIDE_W);
  localparam logic [COORD_W-1:0] YMAX = ymax_f(V_DISP, SIDE_W, BLOCK_W);

  sched_state_t state, state_nxt;

  logic [7:0] step_q;
  logic [7:0] div_q;
  logic [7:0] frame_cnt, frame_cnt_nxt;
  logic       vb_p0, vb_p1;
  logic       vb_rise;
  logic       cfg_xfer;
  logic [8:0] frame_cnt_inc;
  logic [7:0] div_eff;

  logic [COORD_W-1:0] x_calc, y_calc;
  logic               dx_calc, dy_calc;
  logic [COORD_W-1:0] x_p1, y_p1;
  logic               dx_p1, dy_p1;

  // Stage p0/p1: vblank sampled, then delayed once more for edge detection.
  // Both clear on reset, keeping vb_rise low right after reset release.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      vb_p0 <= 1'b0;
      vb_p1 <= 1'b0;
    end else begin
      vb_p0 <= vblank;
      vb_p1 <= vb_p0;
    end
  end

  assign vb_rise       = vb_p0 & ~vb_p1;
  // Ready is gated by rst so it reads 0 while reset is held.
  assign cfg_ready     = ~rst & ((state == ST_IDLE) || (state == ST_WAIT_VB));
  assign cfg_xfer      = cfg_valid & cfg_ready;
  assign div_eff       = (div_q == 8'd0) ? 8'd1 : div_q;
  assign frame_cnt_inc = {1'b0, frame_cnt} + 9'd1;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      frame_cnt <= 8'd0;
      step_q    <= 8'(STEP_INIT);
      div_q     <= 8'(DIV_INIT);
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_cnt_nxt;
      if (cfg_xfer) begin
        step_q <= cfg_step;
        div_q  <= cfg_div;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_WAIT_VB;
      end
      ST_WAIT_VB: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (cfg_xfer) begin
          // A new configuration restarts the frame count; a coincident
          // vblank edge is deliberately dropped.
          frame_cnt_nxt = 8'd0;
        end else if (vb_rise) begin
          if (frame_cnt_inc >= {1'b0, div_eff}) begin
            state_nxt     = ST_CALC;
            frame_cnt_nxt = 8'd0;
          end else begin
            frame_cnt_nxt = frame_cnt_inc[7:0];
          end
        end
      end
      ST_CALC: begin
        state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_nxt = enable ? ST_WAIT_VB : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (cfg_xfer || (state_nxt == ST_IDLE)) frame_cnt_nxt = 8'd0;
  end

  axis_bounce u_axis_x (
    .pos     (block_x),
    .step    (step_q),
    .dir     (dir_x),
    .pos_min (XMIN),
    .pos_max (XMAX),
    .pos_nxt (x_calc),
    .dir_nxt (dx_calc)
  );

  axis_bounce u_axis_y (
    .pos     (block_y),
    .step    (step_q),
    .dir     (dir_y),
    .pos_min (YMIN),
    .pos_max (YMAX),
    .pos_nxt (y_calc),
    .dir_nxt (dy_calc)
  );

  // Stage p1: next position captured at the end of CALC.
  always_ff @(posedge pixel_clk) begin
    if (state == ST_CALC) begin
      x_p1  <= x_calc;
      y_p1  <= y_calc;
      dx_p1 <= dx_calc;
      dy_p1 <= dy_calc;
    end
  end

  // Stage p2: visible outputs, loaded together only when leaving COMMIT.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      block_x <= XMIN;
      block_y <= YMIN;
      dir_x   <= 1'b1;
      dir_y   <= 1'b1;
      pos_upd <= 1'b0;
    end else begin
      pos_upd <= (state == ST_COMMIT);
      if (state == ST_COMMIT) begin
        block_x <= x_p1;
        block_y <= y_p1;
        dir_x   <= dx_p1;
        dir_y   <= dy_p1;
      end
    end
  end

endmodule

// File: tb/tb_video_block_scheduler.sv
module tb_video_block_scheduler;

  localparam int XMIN = 40;
  localparam int XMAX = 1800;
  localparam int YMIN = 40;
  localparam int YMAX = 960;

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic        vblank;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_step;
  logic [7:0]  cfg_div;
  logic [15:0] block_x;
  logic [15:0] block_y;
  logic        dir_x;
  logic        dir_y;
  logic        pos_upd;

  video_block_scheduler dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .vblank    (vblank),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_step  (cfg_step),
    .cfg_div   (cfg_div),
    .block_x   (block_x),
    .block_y   (block_y),
    .dir_x     (dir_x),
    .dir_y     (dir_y),
    .pos_upd   (pos_upd)
  );

  always #5 pixel_clk = ~pixel_clk;

  int cyc = 0;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int cyc;
    int x;
    int y;
    bit dx;
    bit dy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int m_x, m_y, m_step, m_div, m_fcnt;
  bit m_dx, m_dy;

  function automatic void model_reset();
    m_x = XMIN; m_y = YMIN; m_dx = 1; m_dy = 1;
    m_step = 1; m_div = 1; m_fcnt = 0;
  endfunction

  function automatic void move(inout int p, inout bit d, input int s, input int mn, input int mx);
    if (d) begin
      if (p + s >= mx) begin p = mx; d = 0; end
      else p = p + s;
    end else begin
      if (p <= mn + s) begin p = mn; d = 1; end
      else p = p - s;
    end
  endfunction

  // One vblank edge seen by the scheduler in WAIT_VB.
  function automatic void model_edge(input int ec);
    exp_t e;
    int d;
    d = (m_div == 0) ? 1 : m_div;
    if (m_fcnt + 1 >= d) begin
      m_fcnt = 0;
      move(m_x, m_dx, m_step, XMIN, XMAX);
      move(m_y, m_dy, m_step, YMIN, YMAX);
      e.cyc = ec; e.x = m_x; e.y = m_y; e.dx = m_dx; e.dy = m_dy;
      exp_q.push_back(e);
    end else begin
      m_fcnt++;
    end
  endfunction

  // Scoreboard: every pos_upd pulse must match the oldest expectation.
  int  upd_cnt = 0;
  bit  upd_prev = 0;
  always @(negedge pixel_clk) begin
    if (pos_upd) begin
      exp_t e;
      upd_cnt++;
      if (upd_prev) chk("upd_width", 2, 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_upd", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("upd_cycle", cyc, e.cyc);
        chk("upd_x", block_x, e.x);
        chk("upd_y", block_y, e.y);
        chk("upd_dx", dir_x, e.dx);
        chk("upd_dy", dir_y, e.dy);
      end
    end
    upd_prev = pos_upd;
  end

  // vblank rising at a negedge; the following posedge is the sampling edge.
  task automatic frame(input bit expect_edge);
    @(negedge pixel_clk) vblank = 1;
    @(negedge pixel_clk);
    if (expect_edge) model_edge(cyc + 3);
    repeat (3) @(negedge pixel_clk);
    vblank = 0;
    repeat (6) @(negedge pixel_clk);
  endtask

  task automatic do_cfg(input int s, input int d);
    int n;
    @(negedge pixel_clk);
    cfg_valid = 1; cfg_step = 8'(s); cfg_div = 8'(d);
    n = 0;
    while (!cfg_ready && n < 20) begin
      @(negedge pixel_clk);
      n++;
    end
    chk("cfg_ready_wait", cfg_ready, 1);
    @(negedge pixel_clk) cfg_valid = 0;
    m_step = s; m_div = d; m_fcnt = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    rst = 1; vblank = 0; enable = 0; cfg_valid = 0; cfg_step = 0; cfg_div = 0;
    model_reset();
    repeat (3) @(negedge pixel_clk);
    chk("rst_x", block_x, XMIN);
    chk("rst_y", block_y, YMIN);
    chk("rst_dx", dir_x, 1);
    chk("rst_dy", dir_y, 1);
    chk("rst_upd", pos_upd, 0);
    chk("rst_ready", cfg_ready, 0);
    rst = 0;
    @(negedge pixel_clk);
    chk("idle_ready", cfg_ready, 1);

    // Disabled: vblank must not move the square
    frame(0);
    chk("disabled_x", block_x, XMIN);

    // First update
    enable = 1;
    @(negedge pixel_clk);
    frame(1);
    chk("first_x", block_x, 41);
    chk("first_y", block_y, 41);

    // Walk x to 1700, then a big step clamps at XMAX and bounces back
    do_cfg(237, 1);
    repeat (7) frame(1);
    chk("x_1700", block_x, 1700);
    do_cfg(200, 1);
    frame(1);
    chk("x_clamp", block_x, XMAX);
    chk("dx_flip", dir_x, 0);
    frame(1);
    chk("x_back", block_x, 1600);

    // step=0 with div=0: unchanged position, still pulsed
    do_cfg(0, 0);
    c0 = upd_cnt;
    frame(1);
    chk("step0_pulses", upd_cnt - c0, 1);
    chk("step0_x", block_x, 1600);

    // div=3: three updates in nine frames
    do_cfg(1, 3);
    c0 = upd_cnt;
    repeat (9) frame(1);
    chk("div3_pulses", upd_cnt - c0, 3);

    // cfg_valid held from CALC: held off until back in WAIT_VB
    do_cfg(1, 1);
    @(negedge pixel_clk) vblank = 1;
    @(negedge pixel_clk) model_edge(cyc + 3);
    @(negedge pixel_clk);
    cfg_valid = 1; cfg_step = 5; cfg_div = 1;
    chk("ready_calc", cfg_ready, 0);
    @(negedge pixel_clk) chk("ready_commit", cfg_ready, 0);
    @(negedge pixel_clk) chk("ready_back", cfg_ready, 1);
    @(negedge pixel_clk) cfg_valid = 0;
    m_step = 5; m_div = 1; m_fcnt = 0;
    vblank = 0;
    repeat (6) @(negedge pixel_clk);
    frame(1);

    // Transfer coincident with the detected vblank rise: edge ignored
    @(negedge pixel_clk) vblank = 1;
    @(negedge pixel_clk);
    cfg_valid = 1; cfg_step = 9; cfg_div = 2;
    chk("ready_coinc", cfg_ready, 1);
    @(negedge pixel_clk) cfg_valid = 0;
    m_step = 9; m_div = 2; m_fcnt = 0;
    repeat (2) @(negedge pixel_clk);
    vblank = 0;
    repeat (6) @(negedge pixel_clk);
    c0 = upd_cnt;
    frame(1);
    frame(1);
    chk("coinc_div2_pulses", upd_cnt - c0, 1);

    // Reset during COMMIT drops the pending update
    @(negedge pixel_clk) vblank = 1;
    @(negedge pixel_clk) model_edge(cyc + 3);
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    rst = 1;
    #1;
    chk("midrst_x", block_x, XMIN);
    chk("midrst_y", block_y, YMIN);
    chk("midrst_dx", dir_x, 1);
    chk("midrst_dy", dir_y, 1);
    chk("midrst_upd", pos_upd, 0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    model_reset();
    @(negedge pixel_clk);
    rst = 0; vblank = 0;
    repeat (4) @(negedge pixel_clk);
    frame(1);
    chk("after_rst_x", block_x, 41);

    repeat (5) @(negedge pixel_clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/video_block_scheduler.md
VIDEO_BLOCK_SCHEDULER -- requirements
Module: video_block_scheduler

Interface
REQ-001 SHALL have parameter H_DISP, default 1920, active video width in pixels.
REQ-002 SHALL have parameter V_DISP, default 1080, active video height in lines.
REQ-003 SHALL have parameter SIDE_W, default 40, border width in pixels.
REQ-004 SHALL have parameter BLOCK_W, default 80, moving square edge in pixels.
REQ-005 SHALL have parameter STEP_INIT, default 1, pixels moved per update after reset.
REQ-006 SHALL have parameter DIV_INIT, default 1, frames per update after reset.
REQ-007 SHALL have port pixel_clk, input, 1 bit, the only clock.
REQ-008 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-009 SHALL have port vblank, input, 1 bit, vertical blank from the timing generator, active-high.
REQ-010 SHALL have port enable, input, 1 bit, motion enable.
REQ-011 SHALL have port cfg_valid, input, 1 bit, a new configuration is offered.
REQ-012 SHALL have port cfg_ready, output, 1 bit, the block can accept the configuration.
REQ-013 SHALL have port cfg_step, input, 8 bits, pixels per update.
REQ-014 SHALL have port cfg_div, input, 8 bits, frames per update.
REQ-015 SHALL have port block_x, output, 16 bits, left edge of the square.
REQ-016 SHALL have port block_y, output, 16 bits, top edge of the square.
REQ-017 SHALL have port dir_x, output, 1 bit; 1 means moving right.
REQ-018 SHALL have port dir_y, output, 1 bit; 1 means moving down.
REQ-019 SHALL have port pos_upd, output, 1 bit, one-cycle pulse when a new position is committed.

Function
REQ-020 Legal range: x in [XMIN=SIDE_W, XMAX=H_DISP-SIDE_W-BLOCK_W]; y in [YMIN=SIDE_W, YMAX=V_DISP-SIDE_W-BLOCK_W].
REQ-021 FSM states: IDLE, WAIT_VB, CALC, COMMIT.
- IDLE -> WAIT_VB when enable=1.
- WAIT_VB -> CALC on a vblank rising edge once frame_cnt+1 >= div; otherwise that edge only increments frame_cnt.
- CALC -> COMMIT after 1 cycle.
- COMMIT -> WAIT_VB, or IDLE if enable=0.
REQ-022 WAIT_VB SHALL return to IDLE when enable=0; frame_cnt SHALL clear on entry to IDLE.
REQ-023 vblank rising edge SHALL be detected from a registered copy of vblank (1-cycle delay); no edge SHALL be reported in the first cycle after reset.
REQ-024 CALC SHALL compute next x and y in 17-bit unsigned arithmetic, with no wrap.
- Moving forward: if pos+step >= MAX, next=MAX and the direction flips.
- Moving backward: if pos <= MIN+step, next=MIN and the direction flips.
REQ-025 COMMIT SHALL load block_x, block_y, dir_x and dir_y together and assert pos_upd for exactly 1 cycle; the outputs SHALL change only in COMMIT (tear-free, inside vblank).
REQ-026 Latency: pos_upd SHALL assert 3 cycles after the pixel_clk edge that samples vblank high for the first time.
REQ-027 cfg_ready SHALL be 1 only in IDLE or WAIT_VB; a transfer occurs when cfg_valid and cfg_ready are both 1 in the same cycle.
- The transfer loads step and div and clears frame_cnt.
- cfg_valid without cfg_ready SHALL be held off, with nothing captured.
REQ-028 A transfer and a vblank edge in the same cycle: the new config SHALL be captured, frame_cnt cleared, and that edge ignored.
REQ-029 step=0 SHALL commit an unchanged position with pos_upd still pulsed; div=0 SHALL behave as div=1.
REQ-030 A step larger than the range SHALL clamp to the bound and flip, never overshoot.

Reset
REQ-031 On rst=1 the block SHALL asynchronously set:
- block_x=SIDE_W, block_y=SIDE_W, dir_x=1, dir_y=1, pos_upd=0;
- cfg_ready=0 during reset;
- state=IDLE, step=STEP_INIT, div=DIV_INIT, frame_cnt=0, vblank delay register=0.
REQ-032 Reset asserted mid-CALC/COMMIT SHALL drop the pending update, with no pos_upd pulse.

Structure
REQ-033 A shared package video_pkg SHALL hold the FSM state encoding, the 16-bit coordinate width and the XMIN/XMAX/YMIN/YMAX derivation functions.
REQ-034 One sub-module SHALL exist: axis_bounce, combinational next-position and direction for one axis, instantiated twice (x and y).

Verification
REQ-035 Reset release, enable=1, 1 vblank pulse -> pos_upd 3 cycles after the sampled rise; block_x=41, block_y=41, dir_x=1, dir_y=1.
REQ-036 cfg_step=200 with block_x=1700, dir_x=1 -> block_x=1800 (XMAX), dir_x=0; next update block_x=1600.
REQ-037 cfg_div=3 -> pos_upd on every 3rd vblank pulse only, 3 pulses in 9 frames.
REQ-038 cfg_valid held high from CALC -> cfg_ready=0 in CALC/COMMIT; transfer completes the first cycle back in WAIT_VB.
REQ-039 Transfer coincident with a vblank rise -> new step/div captured, no pos_upd for that frame.
REQ-040 rst pulsed during COMMIT -> outputs return to 40/40/1/1 immediately, no pos_upd.
